// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, write-record type and default starvation limit for the register-file write port
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STARVE_LIM_DEF = 3;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: Q_DEPTH-entry FIFO of pending long-latency register writes, head exposed combinationally
module rf_wr_fifo import rf_pkg::*; #(
  parameter int Q_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  rf_wr_t din,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(Q_DEPTH);
  rf_wr_t mem_q [Q_DEPTH];
  rf_wr_t mem_d [Q_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  always_comb begin
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    empty = wp_q == rp_q;
    head = mem_q[rp_q[AW-1:0]];
    do_push = push && !full;
    do_pop = pop && !empty;
    wp_d = wp_q + (AW+1)'(do_push);
    rp_d = rp_q + (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q[AW-1:0]] = din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the RF write port between WB and a buffered long-latency unit, with RAW/WAW scoreboard
// Optional statistics counters enabled by RF_WPORT_STATS_EN.
module rf_wport_arbiter import rf_pkg::*; #(
  parameter int Q_DEPTH = 2,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pipe_hold,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_rd,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  input  logic [ADDR_W-1:0] chk_rd,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata
`ifdef RF_WPORT_STATS_EN
  ,
  output logic [15:0]       stat_hold_cnt,
  output logic [15:0]       stat_lu_wr_cnt
`endif
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int NREG = 1 << ADDR_W;
  rf_wr_t head, lu_wr;
  logic full, empty, wb_live, grant, push;
  logic [SW-1:0] starve_q, starve_d;
  logic [NREG-1:0] busy_q, busy_d;
  rf_wr_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(grant), .din(lu_wr),
    .head(head), .full(full), .empty(empty)
  );
  // WB is masked while in reset so the port stays quiet during reset
  always_comb begin
    wb_live = rst_n && wb_valid && (wb_rd != '0);
    lu_ready = !full;
    lu_wr = '{rd: lu_rd, data: lu_data};
    push = lu_valid && !full && (lu_rd != '0);
    grant = !empty && (!wb_live || starve_q == SW'(STARVE_LIM));
    rf_we = grant || wb_live;
    rf_rd = grant ? head.rd : wb_rd;
    rf_wdata = grant ? head.data : wb_data;
    pipe_hold = grant && wb_live;
    stall = busy_q[chk_rs] | busy_q[chk_rt] | busy_q[chk_rd];
    starve_d = (grant || empty) ? '0 : (starve_q == SW'(STARVE_LIM) ? starve_q : starve_q + SW'(1));
    busy_d = busy_q;
    if (grant) busy_d[head.rd] = 1'b0;
    if (claim_valid) busy_d[claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_q <= '0;
      busy_q <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q <= busy_d;
    end
`ifdef RF_WPORT_STATS_EN
  logic [15:0] hold_cnt_q, hold_cnt_d, lu_wr_cnt_q, lu_wr_cnt_d;
  always_comb begin
    hold_cnt_d = (pipe_hold && hold_cnt_q != 16'hFFFF) ? hold_cnt_q + 16'd1 : hold_cnt_q;
    lu_wr_cnt_d = (grant && lu_wr_cnt_q != 16'hFFFF) ? lu_wr_cnt_q + 16'd1 : lu_wr_cnt_q;
    stat_hold_cnt = hold_cnt_q;
    stat_lu_wr_cnt = lu_wr_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt_q <= '0;
      lu_wr_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      lu_wr_cnt_q <= lu_wr_cnt_d;
    end
`endif
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (WB) and a long-latency unit (LU: mult/div, multi-cycle loads).
- LU results are buffered in a small FIFO and written when WB leaves the port idle.
- A starvation limit forces a queued write through by holding WB for one cycle.
- A 32-entry scoreboard marks registers with outstanding LU writes so decode can stall on RAW and WAW hazards.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
Q_DEPTH, 2, LU write FIFO entries (power of 2, >=2)
STARVE_LIM, 3, max consecutive cycles a non-empty FIFO head may be denied the port

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
wb_valid  in  1  WB write request
wb_rd  in  ADDR_W  WB destination
wb_data  in  DATA_W  WB data
pipe_hold  out  1  WB write not performed this cycle; pipeline must stall MEM/WB and re-present it
lu_valid  in  1  LU result valid
lu_ready  out  1  FIFO can accept
lu_rd  in  ADDR_W  LU destination
lu_data  in  DATA_W  LU data
claim_valid  in  1  decode issues an LU op this cycle
claim_rd  in  ADDR_W  its destination
chk_rs, chk_rt, chk_rd  in  ADDR_W each  decode operand/destination indices
stall  out  1  any checked register busy
rf_we  out  1  register file write enable
rf_rd  out  ADDR_W  register file write index
rf_wdata  out  DATA_W  register file write data

Behaviour:
Interface and reset:
- Single clock clk. Reset rst_n is asynchronous, active-low.
- Reset state: FIFO empty, busy[31:0]=0, starve_cnt=0.
- Output values during reset: rf_we=0, pipe_hold=0, stall=0, lu_ready=1.

WB requests:
- A WB request is live when wb_valid=1 and wb_rd!=0. wb_rd=0 is ignored (no write, no hold).

LU input and FIFO:
- LU handshake: transfer occurs when lu_valid and lu_ready are both 1.
- lu_ready = !full, registered-state-derived only; it never depends on a same-cycle pop.
- A transfer with lu_rd=0 is accepted and dropped (not enqueued).
- Enqueued entries are written in FIFO order.

Port grant (combinational each cycle):
- grant_q = !empty and (!wb_live or starve_cnt==STARVE_LIM).
- If grant_q: rf_we=1, rf_rd/rf_wdata = FIFO head, pop at the edge. pipe_hold = wb_live.
- Else if wb_live: rf_we=1, with WB fields.
- Otherwise rf_we=0.

Starvation counter:
- Cleared on pop or when the FIFO is empty.
- Incremented when the FIFO is non-empty and not granted; saturates at STARVE_LIM.

Latency:
- An LU result accepted at edge N is written no earlier than the end of cycle N+1.
- Worst case is STARVE_LIM+1 cycles after reaching the head.

Scoreboard:
- Claim sets busy[claim_rd] at the edge (claim_rd!=0).
- A pop clears busy[popped rd] at the same edge the register file captures it.
- Claim and clear of the same index in one cycle: set wins.
- busy[0] is always 0.
- stall = busy[chk_rs] | busy[chk_rt] | busy[chk_rd], combinational.

Boundary conditions:
- Full FIFO with a simultaneous pop: no push that cycle.
- WB writing a busy register is a decode error: it is not checked, and the WB write proceeds.
- Reset mid-operation discards queued writes and busy bits.

Optional Feature:
Macro RF_WPORT_STATS_EN.
- Defined: adds outputs stat_hold_cnt[15:0] and stat_lu_wr_cnt[15:0].
  - stat_hold_cnt counts cycles with pipe_hold=1.
  - stat_lu_wr_cnt counts FIFO pops.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rf_pkg: DATA_W, ADDR_W constants; typedef rf_wr_t {rd, data}; STARVE_LIM default.
- Sub-module rf_wr_fifo: parameterised Q_DEPTH FIFO of rf_wr_t with push/pop/full/empty and a head output.
- Arbitration, starvation counter and scoreboard stay in the top level.

Test Plan:
1. Reset, then idle -> rf_we=0, lu_ready=1, stall=0.
2. WB only: wb_rd=5, data 0x1234 -> rf_we=1, rf_rd=5 the same cycle, pipe_hold=0.
3. Claim rd=8; next cycle chk_rs=8 -> stall=1. Then LU pushes rd=8, 0xDEADBEEF while WB is idle -> written in the next cycle, stall=0 the cycle after.
4. Continuous WB live with one queued LU entry, STARVE_LIM=3 -> 3 WB writes, then a queue write with pipe_hold=1 for one cycle, then WB resumes.
5. Fill the FIFO (2 pushes, WB busy) -> lu_ready=0; third lu_valid held until a pop; order preserved.
6. Claim and pop of rd=12 in the same cycle -> busy[12] stays 1. Pushes with rd=0 and wb_rd=0 cause no write and no busy change.
